commit_store_queue: RTL
=======================

// Module: commit_store_queue
// PURPOSE
// - Buffers stores retired by the reorder buffer and drains them in order to the data cache write port.
// - Retirement never stalls on a slow cache write; the ROB stalls only when the queue is full.
// - Supplies store-to-load forwarding for the load unit so loads see committed-but-unwritten data.
// - Entries are architecturally committed and survive ROB flush (resetAll); only reset clears them.
// PARAMETERS
// - DEPTH   4   entries, power of two, >= 2
// - ADDR_W  32  byte address width
// - DATA_W  32  store data width (whole word, no byte enables)
// PORTS
// - clock            in   1       single clock; all state updates on posedge
// - reset            in   1       synchronous, active-high; clears all state
// - enqValid         in   1       ROB commits a store this cycle
// - enqAddr          in   ADDR_W  committed store address
// - enqData          in   DATA_W  committed store data
// - enqReady         out  1       queue not full; ROB commits a store only when high
// - cacheWriteEnable out  1       one-cycle write request to data cache
// - cacheWriteAddr   out  ADDR_W  head entry address, stable from request until done
// - cacheWriteData   out  DATA_W  head entry data, stable from request until done
// - cacheWriteDone   in   1       cache completed the outstanding write (one-cycle pulse)
// - fwdAddr          in   ADDR_W  load unit lookup address
// - fwdHit           out  1       a queued entry matches fwdAddr
// - fwdData          out  DATA_W  data of youngest matching entry; 0 when no hit
// - empty            out  1       no entries, no write outstanding
// - count            out  $clog2(DEPTH)+1  number of valid entries
// BEHAVIOUR
// - Reset values: enqReady=1, cacheWriteEnable=0, addr/data outputs=0, fwdHit=0, fwdData=0, empty=1, count=0, state=IDLE, pointers=0.
// - Storage: circular buffer, head/tail pointers $clog2(DEPTH) bits wrapping modulo DEPTH, plus count register.
// - Enqueue: enqValid && enqReady at posedge writes entry at tail, tail++, count++. enqValid while full is ignored (protocol error; flagged by assertion).
// - enqReady = (count != DEPTH), registered state only; no same-cycle bypass on a freeing dequeue.
// - FSM states:
//   IDLE:  count!=0 -> ISSUE.
//   ISSUE: cacheWriteEnable=1 for exactly this cycle; -> WAIT.
//   WAIT:  hold addr/data from head; on cacheWriteDone: head++, count--, -> ISSUE if count>1 else IDLE.
// - Minimum enqueue-to-write-request latency: 2 cycles (enqueue edge, IDLE->ISSUE edge).
// - Simultaneous enqueue and dequeue (done) in one cycle: count unchanged, both pointers advance.
// - Head entry remains valid and forwardable until its cacheWriteDone edge.
// - cacheWriteDone outside WAIT is ignored.
// - Forwarding: combinational search over all valid entries; youngest match (nearest tail) wins; compares full ADDR_W bits.
// - Reset mid-write: state -> IDLE, queue emptied immediately; a later cacheWriteDone is ignored.
// - resetAll (ROB flush) is deliberately not an input; queued stores are never discarded except by reset.
// STRUCTURE
// - Shared package: FSM state encoding (SQ_IDLE, SQ_ISSUE, SQ_WAIT), DEPTH/width defaults.
// - One sub-module: sq_fwd_match (combinational youngest-match priority selector over DEPTH entries).
// - Top-level cpu: enqueue from reorderBuffer commit; cacheWrite* replaces the direct ROB->dataCache write wiring; fwd* to loadUnit.
// TESTING
// - Reset: assert reset 2 cycles -> empty=1, count=0, enqReady=1, cacheWriteEnable=0.
// - Single store: enq (0x10, 0xAB) -> cacheWriteEnable high exactly 2 cycles later for 1 cycle with addr 0x10, data 0xAB; done -> empty=1.
// - Fill: 4 enqs with done held low -> count=4, enqReady=0; 5th enqValid ignored; done pulses drain in FIFO order.
// - Forwarding: enq (0x20,1),(0x24,2),(0x20,3); fwdAddr=0x20 -> fwdHit=1, fwdData=3; fwdAddr=0x28 -> fwdHit=0, fwdData=0.
// - Simultaneous: count=2 in WAIT, enq and done same cycle -> count stays 2, next ISSUE uses second entry, tail wraps correctly past DEPTH.
// - Reset mid-write: reset during WAIT, then cacheWriteDone pulse -> state IDLE, count=0, no pointer movement.

Source files
------------

// File: rtl/commit_store_queue_pkg.sv
// Shared definitions for the commit store queue.
// - Default geometry (depth, address and data widths).
// - FSM state encoding for the cache-write sequencer.
package commit_store_queue_pkg;

  localparam int SQ_DEPTH  = 4;
  localparam int SQ_ADDR_W = 32;
  localparam int SQ_DATA_W = 32;

  // Write sequencer states: IDLE waits for a queued entry, ISSUE raises the
  // one-cycle cache request, WAIT holds the head until the cache reports done.
  typedef logic [1:0] sq_state_t;
  localparam logic [1:0] SQ_IDLE  = 2'd0;
  localparam logic [1:0] SQ_ISSUE = 2'd1;
  localparam logic [1:0] SQ_WAIT  = 2'd2;

endpackage

// File: rtl/commit_store_queue_if.sv
// Bus bundle between the commit store queue and its neighbours.
// - enq*        : committed stores from the reorder buffer (enqReady back-pressure)
// - cacheWrite* : one-outstanding write port into the data cache
// - fwd*        : store-to-load forwarding lookup for the load unit
// - empty/count : occupancy status
// master = surrounding pipeline (ROB, cache, load unit); slave = the queue.
interface commit_store_queue_if
  import commit_store_queue_pkg::*;
#(
  parameter int DEPTH  = SQ_DEPTH,
  parameter int ADDR_W = SQ_ADDR_W,
  parameter int DATA_W = SQ_DATA_W
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enqValid;
  logic [ADDR_W-1:0] enqAddr;
  logic [DATA_W-1:0] enqData;
  logic              enqReady;

  logic              cacheWriteEnable;
  logic [ADDR_W-1:0] cacheWriteAddr;
  logic [DATA_W-1:0] cacheWriteData;
  logic              cacheWriteDone;

  logic [ADDR_W-1:0] fwdAddr;
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;

  logic              empty;
  logic [CNT_W-1:0]  count;

  modport master (
    output enqValid, enqAddr, enqData, cacheWriteDone, fwdAddr,
    input  enqReady, cacheWriteEnable, cacheWriteAddr, cacheWriteData,
           fwdHit, fwdData, empty, count
  );

  modport slave (
    input  enqValid, enqAddr, enqData, cacheWriteDone, fwdAddr,
    output enqReady, cacheWriteEnable, cacheWriteAddr, cacheWriteData,
           fwdHit, fwdData, empty, count
  );

endinterface

// File: rtl/commit_store_queue_sq_fwd_match.sv
// sq_fwd_match: youngest-match priority selector for store-to-load forwarding.
// Ports:
// - key        : load address to look up (full-width compare)
// - addr_ord   : entry addresses, index 0 = oldest (head), DEPTH-1 = youngest slot
// - data_ord   : entry data in the same age order
// - valid_ord  : per-slot valid in the same age order
// - hit / data : any valid match, and data of the youngest match (0 on miss)
module sq_fwd_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] key,
  input  logic [ADDR_W-1:0] addr_ord [DEPTH],
  input  logic [DATA_W-1:0] data_ord [DEPTH],
  input  logic [DEPTH-1:0]  valid_ord,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Scan oldest to youngest so a later (younger) match overrides earlier ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_ord[k] && (addr_ord[k] == key)) begin
        hit  = 1'b1;
        data = data_ord[k];
      end
    end
  end

endmodule

// File: rtl/commit_store_queue.sv
// commit_store_queue: buffers retired stores and drains them in order to the
// data cache write port, with store-to-load forwarding from queued entries.
// Ports:
// - clock, reset : single clock, synchronous active-high reset
// - sq (slave)   : enq* from the ROB, cacheWrite* to the data cache,
//                  fwd* to the load unit, empty/count status
// Entries are architecturally committed; only reset discards them.
module commit_store_queue
  import commit_store_queue_pkg::*;
#(
  parameter int DEPTH     = SQ_DEPTH,
  parameter int ADDR_W    = SQ_ADDR_W,
  parameter int DATA_W    = SQ_DATA_W,
  parameter bit ASSERT_EN = 1'b1
) (
  input logic                 clock,
  input logic                 reset,
  commit_store_queue_if.slave sq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]        state_reg, state_next;
  logic [PTR_W-1:0]  head_reg, tail_reg;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              full, enq_fire, deq_fire;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign enq_fire = sq.enqValid && !full;
  // Done is only meaningful while a write is outstanding.
  assign deq_fire = (state_reg == SQ_WAIT) && sq.cacheWriteDone;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SQ_IDLE:  if (count_reg != '0) state_next = SQ_ISSUE;
      SQ_ISSUE: state_next = SQ_WAIT;
      SQ_WAIT:  if (sq.cacheWriteDone)
                  state_next = (count_reg > CNT_W'(1)) ? SQ_ISSUE : SQ_IDLE;
      default:  state_next = SQ_IDLE;
    endcase
  end

  // Simultaneous enqueue and dequeue leave the count unchanged.
  always_comb begin
    count_next = count_reg;
    case ({enq_fire, deq_fire})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= SQ_IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (enq_fire) tail_reg <= tail_reg + PTR_W'(1);
      if (deq_fire) head_reg <= head_reg + PTR_W'(1);
    end
  end

  // Entry storage needs no reset: validity is derived from head/count.
  always_ff @(posedge clock) begin
    if (!reset && enq_fire) begin
      addr_mem[tail_reg] <= sq.enqAddr;
      data_mem[tail_reg] <= sq.enqData;
    end
  end

  // Present entries to the matcher in age order (slot 0 = head).
  logic [ADDR_W-1:0] addr_ord [DEPTH];
  logic [DATA_W-1:0] data_ord [DEPTH];
  logic [DEPTH-1:0]  valid_ord;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_order
    logic [PTR_W-1:0] slot;
    assign slot          = head_reg + PTR_W'(gi);
    assign addr_ord[gi]  = addr_mem[slot];
    assign data_ord[gi]  = data_mem[slot];
    assign valid_ord[gi] = (CNT_W'(gi) < count_reg);
  end

  sq_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fwd_match (
    .key       (sq.fwdAddr),
    .addr_ord  (addr_ord),
    .data_ord  (data_ord),
    .valid_ord (valid_ord),
    .hit       (sq.fwdHit),
    .data      (sq.fwdData)
  );

  // Head stays on the write port for the whole ISSUE/WAIT window.
  assign sq.enqReady         = !full;
  assign sq.cacheWriteEnable = (state_reg == SQ_ISSUE);
  assign sq.cacheWriteAddr   = (state_reg != SQ_IDLE) ? addr_mem[head_reg] : '0;
  assign sq.cacheWriteData   = (state_reg != SQ_IDLE) ? data_mem[head_reg] : '0;
  assign sq.empty            = (count_reg == '0) && (state_reg == SQ_IDLE);
  assign sq.count            = count_reg;

  // The ROB must not present a store while the queue is full.
  if (ASSERT_EN) begin : g_proto_chk
    assert property (@(posedge clock) disable iff (reset) !(sq.enqValid && full));
  end

endmodule
